div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 160 ++++++++++++++++
 tb/tb_div_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit divider for the execute stage: signed/unsigned restoring division,
// one quotient bit per clock, result {remainder, quotient} destined for HI/LO.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 Rst_n,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [5:0]    cnt_r, cnt_s;
    logic [64:0]   dividend_r, dividend_s;
    logic [31:0]   divisor_r, divisor_s;
    logic          signed_r, signed_s;
    logic          sign1_r, sign1_s;
    logic          sign2_r, sign2_s;
    logic [63:0]   result_s;
    logic          ready_s;

    logic [31:0]   mag1_s, mag2_s;
    logic [64:0]   shifted_s;
    logic [32:0]   diff_s;
    logic [64:0]   step_s;
    logic [31:0]   quot_s, rem_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
    assign mag1_s = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
    assign mag2_s = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;

    // Restoring step: shift, trial-subtract from the upper 33 bits, keep if non-negative.
    assign shifted_s = dividend_r << 1'b1;
    assign diff_s    = shifted_s[64:32] - {1'b0, divisor_r};
    assign step_s    = diff_s[32] ? shifted_s : {diff_s, shifted_s[31:1], 1'b1};

    // Next-state and next-output logic for the FREE/BYZERO/ON/END sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        dividend_s = dividend_r;
        divisor_s  = divisor_r;
        signed_s   = signed_r;
        sign1_s    = sign1_r;
        sign2_s    = sign2_r;
        result_s   = result_o;
        ready_s    = ready_o;
        quot_s     = dividend_r[31:0];
        rem_s      = dividend_r[63:32];

        case (state_r)
            FREE: begin
                ready_s  = 1'b0;
                result_s = 64'd0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_s = BYZERO;
                    end else begin
                        state_s    = ON;
                        cnt_s      = 6'd0;
                        dividend_s = {33'd0, mag1_s};
                        divisor_s  = mag2_s;
                        signed_s   = signed_div_i;
                        sign1_s    = opdata1_i[31];
                        sign2_s    = opdata2_i[31];
                    end
                end else begin
                    state_s = FREE;
                end
            end
            BYZERO: begin
                state_s  = END;
                result_s = 64'd0;
                ready_s  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_s = FREE;
                    cnt_s   = 6'd0;
                    ready_s = 1'b0;
                end else if (cnt_r == 6'd32) begin
                    if (signed_r && (sign1_r ^ sign2_r)) begin
                        quot_s = neg32(dividend_r[31:0]);
                    end else begin
                        quot_s = dividend_r[31:0];
                    end
                    if (signed_r && sign1_r) begin
                        rem_s = neg32(dividend_r[63:32]);
                    end else begin
                        rem_s = dividend_r[63:32];
                    end
                    state_s  = END;
                    cnt_s    = 6'd0;
                    result_s = {rem_s, quot_s};
                    ready_s  = 1'b1;
                end else begin
                    dividend_s = step_s;
                    cnt_s      = cnt_r + 6'd1;
                end
            end
            END: begin
                if (start_i) begin
                    state_s = END;
                end else begin
                    state_s  = FREE;
                    result_s = 64'd0;
                    ready_s  = 1'b0;
                end
            end
            default: begin
                state_s  = FREE;
                cnt_s    = 6'd0;
                result_s = 64'd0;
                ready_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_r    <= FREE;
            cnt_r      <= 6'd0;
            dividend_r <= 65'd0;
            divisor_r  <= 32'd0;
            signed_r   <= 1'b0;
            sign1_r    <= 1'b0;
            sign2_r    <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            dividend_r <= dividend_s;
            divisor_r  <= divisor_s;
            signed_r   <= signed_s;
            sign1_r    <= sign1_s;
            sign2_r    <= sign2_s;
            result_o   <= result_s;
            ready_o    <= ready_s;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// annul, and mid-operation reset, checked with immediate assertions.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .Rst_n        (Rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide; operands are scrambled right after the accept edge E0.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic hold, input logic [63:0] exp);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(negedge clk);
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h5A5A_0001;
        signed_div_i = ~sgn;
        start_i      = hold;
        repeat (32) @(negedge clk);
        check({tag, "_early"}, {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        check({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
        check({tag, "_result"}, result_o, exp);
        if (hold) begin
            @(negedge clk);
            check({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
            check({tag, "_hold_result"}, result_o, exp);
            start_i = 1'b0;
        end else begin
            start_i = 1'b0;
        end
        @(negedge clk);
        check({tag, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
        check({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        int pulses;
        Rst_n        = 1'b0;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        repeat (3) @(negedge clk);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        Rst_n   = 1'b1;
        start_i = 1'b0;
        @(negedge clk);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 1'b1, {32'h0000_0002, 32'h0000_000E});
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div("s_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
        run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000});
        run_div("u_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0000_0000});
        run_div("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1, {32'h0000_000F, 32'h0FFF_FFFF});

        // Divide by zero: one-cycle latency, zero result.
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'd123;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        @(negedge clk);
        check("dz_e0_ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        check("dz_e1_ready", {63'd0, ready_o}, 64'd1);
        check("dz_e1_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        check("dz_drop_ready", {63'd0, ready_o}, 64'd0);

        // Annul at cycle 10 of ON, then hold start with annul to show FREE refuses it.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) pulses++;
        end
        check("annul_no_pulse", 64'(pulses), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        run_div("u20_3", 1'b0, 32'd20, 32'd3, 1'b1, {32'd2, 32'd6});

        // Reset at cycle 15 of ON, with start still high on the reset edge.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd4;
        start_i      = 1'b1;
        @(negedge clk);
        repeat (14) @(negedge clk);
        Rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        Rst_n   = 1'b1;
        start_i = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) pulses++;
        end
        check("rst_no_pulse", 64'(pulses), 64'd0);
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 1'b1, {32'd0, 32'd3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
